// File: rtl/ws2812_frame_driver.sv
// WS2812 one-wire frame serialiser: fetches NUM_LEDS GRB colours via pixel_idx/color_in,
// shifts them out MSB first with WS2812 bit timing, then holds the line low for the latch time.
module ws2812_frame_driver #(
    parameter int NUM_LEDS     = 8,
    parameter int BIT_CYCLES   = 63,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int RESET_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] color_in,
    output logic [7:0]  pixel_idx,
    output logic        dout,
    output logic        busy,
    output logic        done
);

    localparam int TW = $clog2(BIT_CYCLES + 1);
    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] LOW0     = TW'(BIT_CYCLES - T0H_CYCLES);
    localparam logic [TW-1:0] LOW1     = TW'(BIT_CYCLES - T1H_CYCLES);
    localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYCLES - 1);
    localparam logic [7:0]    IDX_LAST = 8'(NUM_LEDS - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES &&
          RESET_CYCLES >= 1 && NUM_LEDS >= 1 && NUM_LEDS <= 256)) begin : g_bad_params
        $error("ws2812_frame_driver: illegal timing or NUM_LEDS parameters");
    end

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t        state, state_n;
    logic [23:0]   shreg, shreg_n;
    logic [4:0]    bit_cnt, bit_cnt_n;
    logic [TW-1:0] bit_tmr, bit_tmr_n;
    logic [LW-1:0] lat_tmr, lat_tmr_n;
    logic [7:0]    pix_left, pix_left_n;
    logic [7:0]    pixel_idx_n;
    logic          dout_n, done_n, load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            bit_tmr   <= '0;
            lat_tmr   <= '0;
            pix_left  <= '0;
            pixel_idx <= '0;
            dout      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            bit_tmr   <= bit_tmr_n;
            lat_tmr   <= lat_tmr_n;
            pix_left  <= pix_left_n;
            pixel_idx <= pixel_idx_n;
            dout      <= dout_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        bit_tmr_n   = bit_tmr;
        lat_tmr_n   = lat_tmr;
        pix_left_n  = pix_left;
        pixel_idx_n = pixel_idx;
        dout_n      = 1'b0;
        done_n      = 1'b0;
        load        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    pix_left_n = IDX_LAST;
                end
            end
            SEND: begin
                if (bit_tmr == '0) begin
                    if (bit_cnt != 5'd0) begin
                        shreg_n   = {shreg[22:0], 1'b0};
                        bit_cnt_n = bit_cnt - 5'd1;
                        bit_tmr_n = BIT_LAST;
                        dout_n    = 1'b1;
                    end else if (pix_left != 8'd0) begin
                        load       = 1'b1;
                        pix_left_n = pix_left - 8'd1;
                    end else begin
                        state_n   = LATCH;
                        lat_tmr_n = LAT_LAST;
                    end
                end else begin
                    bit_tmr_n = bit_tmr - TW'(1);
                    // line stays high while the next cycle is still inside the high window
                    dout_n    = bit_tmr > (shreg[23] ? LOW1 : LOW0);
                end
            end
            LATCH: begin
                if (lat_tmr == '0) begin
                    state_n     = IDLE;
                    done_n      = 1'b1;
                    pixel_idx_n = 8'd0;
                end else begin
                    lat_tmr_n = lat_tmr - LW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // pixel_idx saturates on the last pixel so upstream never sees an out-of-range index
        if (load) begin
            state_n   = SEND;
            shreg_n   = color_in;
            bit_cnt_n = 5'd23;
            bit_tmr_n = BIT_LAST;
            dout_n    = 1'b1;
            if (pixel_idx != IDX_LAST)
                pixel_idx_n = pixel_idx + 8'd1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Directed bench for ws2812_frame_driver: one-pixel and two-pixel instances with default timing,
// waveforms logged per cycle and compared against hand-derived WS2812 bit timing.
module tb_ws2812_frame_driver;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset, start_req, sel;
    logic [23:0] color1, color2;
    logic        start1, start2;
    logic [7:0]  pidx1, pidx2;
    logic        dout1, dout2, busy1, busy2, done1, done2;

    assign start1 = start_req & ~sel;
    assign start2 = start_req & sel;
    always_comb color2 = (pidx2 == 8'd0) ? 24'hFF0000 : 24'h0000FF;

    ws2812_frame_driver #(.NUM_LEDS(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .color_in(color1),
        .pixel_idx(pidx1), .dout(dout1), .busy(busy1), .done(done1));

    ws2812_frame_driver #(.NUM_LEDS(2)) u2 (
        .clk(clk), .reset(reset), .start(start2), .color_in(color2),
        .pixel_idx(pidx2), .dout(dout2), .busy(busy2), .done(done2));

    wire       dout_s = sel ? dout2 : dout1;
    wire       busy_s = sel ? busy2 : busy1;
    wire       done_s = sel ? done2 : done1;
    wire [7:0] idx_s  = sel ? pidx2 : pidx1;

    int vectors = 0;
    int errors  = 0;

    logic       dout_log [1:8100];
    logic       busy_log [1:8100];
    logic       done_log [1:8100];
    logic [7:0] idx_log  [1:8100];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // cycle 1 is the cycle right after the edge that accepts start
    task automatic run(input int ncyc, input int hold_until, input int pulse_at,
                       input int chg_at, input logic [23:0] chg_col);
        start_req = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            dout_log[c] = dout_s;
            busy_log[c] = busy_s;
            done_log[c] = done_s;
            idx_log[c]  = idx_s;
            start_req   = (c < hold_until) || (c == pulse_at);
            if (c == chg_at) color1 = chg_col;
            @(negedge clk);
        end
        start_req = 1'b0;
    endtask

    function automatic logic exp_dout(input int c, input int nbits, input logic [47:0] stream);
        int k, pos;
        if (c > nbits * 63) return 1'b0;
        k   = (c - 1) / 63;
        pos = (c - 1) % 63;
        return pos < (stream[nbits - 1 - k] ? 40 : 20);
    endfunction

    function automatic int wave_errs(input int ofs, input int nbits, input logic [47:0] stream);
        int n = 0;
        for (int c = 1; c <= nbits * 63 + 2500; c++)
            if (dout_log[ofs + c] !== exp_dout(c, nbits, stream)) n++;
        return n;
    endfunction

    function automatic int busy_gaps(input int ofs, input int len);
        int n = 0;
        for (int c = 1; c <= len; c++)
            if (busy_log[ofs + c] !== 1'b1) n++;
        return n;
    endfunction

    function automatic int count_high(input int from, input int to, input bit use_done);
        int n = 0;
        for (int c = from; c <= to; c++)
            if ((use_done ? done_log[c] : dout_log[c]) === 1'b1) n++;
        return n;
    endfunction

    initial begin
        int bad1, bad2;
        reset = 1'b1; start_req = 1'b0; sel = 1'b0; color1 = 24'h0;
        repeat (3) @(negedge clk);
        chk("rst_dout", {31'b0, dout1}, 0);
        chk("rst_busy", {31'b0, busy1}, 0);
        chk("rst_done", {31'b0, done2}, 0);
        chk("rst_idx",  {24'b0, pidx2}, 0);
        reset = 1'b0;

        bad1 = 0; bad2 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dout1 || busy1 || done1 || pidx1 != 8'd0) bad1++;
            if (dout2 || busy2 || done2 || pidx2 != 8'd0) bad2++;
        end
        chk("idle_u1", bad1, 0);
        chk("idle_u2", bad2, 0);

        // one pixel 800001, single start pulse
        color1 = 24'h800001;
        run(4013, 1, 0, 0, 24'h0);
        chk("p1_bit23_high", count_high(1, 63, 0), 40);
        chk("p1_bit22_high", count_high(64, 126, 0), 20);
        chk("p1_bit0_high",  count_high(1450, 1512, 0), 40);
        chk("p1_bit23_fall", {31'b0, dout_log[41]}, 0);
        chk("p1_wave",       wave_errs(0, 24, {24'h0, 24'h800001}), 0);
        chk("p1_latch_low",  count_high(1513, 4012, 0), 0);
        chk("p1_busy",       busy_gaps(0, 4012), 0);
        chk("p1_early_done", count_high(1, 4012, 1), 0);
        chk("p1_done",       {31'b0, done_log[4013]}, 1);
        chk("p1_busy_done",  {31'b0, busy_log[4013]}, 0);
        chk("p1_idx",        {24'b0, idx_log[100]}, 0);

        // two pixels, colour derived from pixel_idx
        sel = 1'b1;
        run(5525, 1, 0, 0, 24'h0);
        chk("p2_wave",       wave_errs(0, 48, {24'hFF0000, 24'h0000FF}), 0);
        chk("p2_idx_pix0",   {24'b0, idx_log[100]}, 1);
        chk("p2_idx_pix1",   {24'b0, idx_log[2000]}, 1);
        chk("p2_no_gap",     {31'b0, dout_log[1513]}, 1);
        chk("p2_b24_fall",   {31'b0, dout_log[1533]}, 0);
        chk("p2_busy",       busy_gaps(0, 5524), 0);
        chk("p2_done",       {31'b0, done_log[5525]}, 1);
        chk("p2_idx_end",    {24'b0, idx_log[5525]}, 0);
        sel = 1'b0;

        // start held high: back-to-back frames of 000000
        color1 = 24'h000000;
        run(8027, 5000, 0, 0, 24'h0);
        chk("bb_wave1",      wave_errs(0, 24, 48'h0), 0);
        chk("bb_done1",      {31'b0, done_log[4013]}, 1);
        chk("bb_dout_done",  {31'b0, dout_log[4013]}, 0);
        chk("bb_rise",       {31'b0, dout_log[4014]}, 1);
        chk("bb_busy2",      {31'b0, busy_log[4014]}, 1);
        chk("bb_wave2",      wave_errs(4013, 24, 48'h0), 0);
        chk("bb_mid_done",   count_high(4014, 8025, 1), 0);
        chk("bb_done2",      {31'b0, done_log[8026]}, 1);
        chk("bb_idle",       {31'b0, busy_log[8027]}, 0);

        // colour changed at bit 10 plus a stray start pulse mid-frame
        color1 = 24'hFFFFFF;
        run(4013, 1, 700, 820, 24'h000000);
        chk("cc_wave",       wave_errs(0, 24, {24'h0, 24'hFFFFFF}), 0);
        chk("cc_done",       {31'b0, done_log[4013]}, 1);
        run(4013, 1, 0, 0, 24'h0);
        chk("cc_next_wave",  wave_errs(0, 24, 48'h0), 0);

        // reset at bit 5 of pixel 0
        color1 = 24'h00FF00;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        repeat (1134) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rm_dout", {31'b0, dout1}, 0);
        chk("rm_busy", {31'b0, busy1}, 0);
        chk("rm_idx",  {24'b0, pidx1}, 0);
        reset = 1'b0;
        bad1 = 0;
        for (int i = 0; i < 2600; i++) begin
            @(negedge clk);
            if (done1 || busy1 || dout1) bad1++;
        end
        chk("rm_quiet", bad1, 0);
        run(4013, 1, 0, 0, 24'h0);
        chk("rm_fresh_wave", wave_errs(0, 24, {24'h0, 24'h00FF00}), 0);
        chk("rm_fresh_done", {31'b0, done_log[4013]}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
